// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the writeback path.
package cpu_pkg;

  localparam int REG_SIZE  = 32;
  localparam int REG_IDX_W = 5;
  localparam int TIMEOUT   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write storage: circular buffer with head view and an age-ordered
// entry view (index 0 = oldest) used by the hazard/bypass search.
module wb_fifo #(
  parameter int DATA_W = cpu_pkg::REG_SIZE,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  push_reg,
  input  logic [DATA_W-1:0]              push_data,
  output logic [cpu_pkg::REG_IDX_W-1:0]  head_reg,
  output logic [DATA_W-1:0]              head_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic [cpu_pkg::REG_IDX_W-1:0]  ent_reg  [DEPTH],
  output logic [DATA_W-1:0]              ent_data [DEPTH],
  output logic [DEPTH-1:0]               ent_valid
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_IDX_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0]    mem_data [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage; contents outside the valid window are don't-care.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr]  <= push_reg;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign head_reg  = mem_reg[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Age-ordered view so the bypass search can let younger entries win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_reg[i]   = mem_reg[rd_ptr + PW'(i)];
      ent_data[i]  = mem_data[rd_ptr + PW'(i)];
      ent_valid[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers producer results and retires them one at a time
// to the register file, with hazard detection and youngest-value bypass.
//
//   state | meaning
//   IDLE  | no write in flight; start one when the queue is non-empty
//   WRITE | strobe the head entry into the register file (one cycle)
//   WAIT  | hold the head until acknowledge or timeout, then pop it
module writeback_queue #(
  parameter int REG_SIZE = cpu_pkg::REG_SIZE,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = cpu_pkg::TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [cpu_pkg::REG_IDX_W-1:0] in_reg,
  input  logic [REG_SIZE-1:0]           in_data,
  output logic [cpu_pkg::REG_IDX_W-1:0] write_register,
  output logic [REG_SIZE-1:0]           write_data,
  output logic                          write_register_enable,
  input  logic                          register_writing_done,
  input  logic [cpu_pkg::REG_IDX_W-1:0] query_reg_1,
  input  logic [cpu_pkg::REG_IDX_W-1:0] query_reg_2,
  output logic                          pending_1,
  output logic                          pending_2,
  output logic [REG_SIZE-1:0]           bypass_data_1,
  output logic [REG_SIZE-1:0]           bypass_data_2,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          wb_timeout
);
  import cpu_pkg::*;

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WCW = $clog2(TIMEOUT + 1);

  wb_state_t            state, state_nxt;
  logic [WCW-1:0]       wait_cnt, wait_cnt_nxt;
  logic                 timeout_nxt;
  logic                 push;
  logic                 pop;
  logic [REG_IDX_W-1:0] head_reg;
  logic [REG_SIZE-1:0]  head_data;
  logic [REG_IDX_W-1:0] ent_reg  [DEPTH];
  logic [REG_SIZE-1:0]  ent_data [DEPTH];
  logic [DEPTH-1:0]     ent_valid;

  // Register 0 is hardwired: accept the handshake but never enqueue it.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_reg != '0);

  wb_fifo #(
    .DATA_W (REG_SIZE),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_reg  (in_reg),
    .push_data (in_data),
    .head_reg  (head_reg),
    .head_data (head_data),
    .count     (count),
    .ent_reg   (ent_reg),
    .ent_data  (ent_data),
    .ent_valid (ent_valid)
  );

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      wb_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      wb_timeout <= timeout_nxt;
    end
  end

  // Next-state and register-file port drive.
  always_comb begin
    state_nxt             = state;
    wait_cnt_nxt          = wait_cnt;
    timeout_nxt           = wb_timeout;
    pop                   = 1'b0;
    write_register_enable = 1'b0;
    write_register        = '0;
    write_data            = '0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = WRITE;
      end
      WRITE: begin
        write_register_enable = 1'b1;
        write_register        = head_reg;
        write_data            = head_data;
        state_nxt             = WAIT;
      end
      WAIT: begin
        write_register = head_reg;
        write_data     = head_data;
        if (register_writing_done) begin
          pop          = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th in WAIT: give up on the entry.
          timeout_nxt  = 1'b1;
          pop          = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hazard search oldest-to-youngest so the youngest match overrides.
  always_comb begin
    pending_1     = 1'b0;
    pending_2     = 1'b0;
    bypass_data_1 = '0;
    bypass_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (query_reg_1 != '0) && (ent_reg[i] == query_reg_1)) begin
        pending_1     = 1'b1;
        bypass_data_1 = ent_data[i];
      end
      if (ent_valid[i] && (query_reg_2 != '0) && (ent_reg[i] == query_reg_2)) begin
        pending_2     = 1'b1;
        bypass_data_2 = ent_data[i];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a strobe scoreboard.
module tb_writeback_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_register_enable;
  logic        register_writing_done;
  logic [4:0]  query_reg_1;
  logic [4:0]  query_reg_2;
  logic        pending_1;
  logic        pending_2;
  logic [31:0] bypass_data_1;
  logic [31:0] bypass_data_2;
  logic [2:0]  count;
  logic        wb_timeout;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_en = 1'b0;

  writeback_queue #(.REG_SIZE(32), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_reg                (in_reg),
    .in_data               (in_data),
    .write_register        (write_register),
    .write_data            (write_data),
    .write_register_enable (write_register_enable),
    .register_writing_done (register_writing_done),
    .query_reg_1           (query_reg_1),
    .query_reg_2           (query_reg_2),
    .pending_1             (pending_1),
    .pending_2             (pending_2),
    .bypass_data_1         (bypass_data_1),
    .bypass_data_2         (bypass_data_2),
    .count                 (count),
    .wb_timeout            (wb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write and last one cycle.
  always @(negedge clk) begin
    if (!rst && write_register_enable) begin
      checks++;
      if (prev_en) begin
        errors++;
        $display("FAIL strobe_width: enable high on consecutive cycles");
      end
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: reg %0d data %0h, none expected", write_register, write_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("strobe_reg", {27'd0, write_register}, {27'd0, e.r});
        check("strobe_data", write_data, e.d);
      end
    end
    prev_en = write_register_enable;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    if (r != 5'd0) begin
      exp_t e;
      e.r = r;
      e.d = d;
      expq.push_back(e);
    end
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    while (!write_register_enable && n < 50) begin
      step();
      n++;
    end
    check("strobe_seen", {31'd0, write_register_enable}, 32'd1);
  endtask

  task automatic drain(input int k);
    repeat (k) begin
      wait_strobe();
      step();
      register_writing_done = 1'b1;
      step();
      register_writing_done = 1'b0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_reg = '0;
    in_data = '0;
    register_writing_done = 1'b0;
    query_reg_1 = '0;
    query_reg_2 = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_enable", {31'd0, write_register_enable}, 32'd0);
    check("rst_wreg", {27'd0, write_register}, 32'd0);
    check("rst_timeout", {31'd0, wb_timeout}, 32'd0);

    // Single write with latency and ack two cycles after strobe
    query_reg_1 = 5'd5;
    push(5'd5, 32'hDEADBEEF);
    check("lat_no_enable_yet", {31'd0, write_register_enable}, 32'd0);
    check("single_count", {29'd0, count}, 32'd1);
    check("single_pending", {31'd0, pending_1}, 32'd1);
    check("single_bypass", bypass_data_1, 32'hDEADBEEF);
    step();
    check("lat_enable", {31'd0, write_register_enable}, 32'd1);
    step();
    check("wait_enable_low", {31'd0, write_register_enable}, 32'd0);
    check("wait_hold_data", write_data, 32'hDEADBEEF);
    step();
    register_writing_done = 1'b1;
    step();
    register_writing_done = 1'b0;
    check("single_count_after", {29'd0, count}, 32'd0);
    check("single_pending_after", {31'd0, pending_1}, 32'd0);

    // Full queue
    push(5'd1, 32'h101);
    push(5'd2, 32'h102);
    push(5'd3, 32'h103);
    push(5'd4, 32'h104);
    check("full_count", {29'd0, count}, 32'd4);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_reg   = 5'd6;
    in_data  = 32'h106;
    step();
    check("full_reject_count", {29'd0, count}, 32'd4);
    register_writing_done = 1'b1;
    step();
    register_writing_done = 1'b0;
    check("full_pop_count", {29'd0, count}, 32'd3);
    check("full_pop_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    begin
      exp_t e;
      e.r = 5'd6;
      e.d = 32'h106;
      expq.push_back(e);
    end
    check("full_refill_count", {29'd0, count}, 32'd4);
    drain(4);
    check("full_drained", {29'd0, count}, 32'd0);

    // Bypass: youngest of two writes to the same register
    query_reg_1 = 5'd7;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    check("byp_pending", {31'd0, pending_1}, 32'd1);
    check("byp_data", bypass_data_1, 32'h22);
    drain(1);
    check("byp_pending_mid", {31'd0, pending_1}, 32'd1);
    check("byp_data_mid", bypass_data_1, 32'h22);
    drain(1);
    check("byp_pending_end", {31'd0, pending_1}, 32'd0);
    check("byp_data_end", bypass_data_1, 32'h0);

    // Register zero is discarded
    query_reg_2 = 5'd0;
    push(5'd0, 32'hABC);
    check("zero_count", {29'd0, count}, 32'd0);
    check("zero_pending", {31'd0, pending_2}, 32'd0);
    repeat (4) step();

    // Timeout: exactly TIMEOUT WAIT cycles after the strobe
    push(5'd3, 32'h33);
    wait_strobe();
    n = 0;
    while (!wb_timeout && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycles", n, 32'd16);
    check("timeout_flag", {31'd0, wb_timeout}, 32'd1);
    check("timeout_dropped", {29'd0, count}, 32'd0);
    check("timeout_enable", {31'd0, write_register_enable}, 32'd0);
    push(5'd9, 32'h99);
    drain(1);
    check("post_timeout_count", {29'd0, count}, 32'd0);
    check("timeout_sticky", {31'd0, wb_timeout}, 32'd1);

    // Reset during WAIT with three entries
    query_reg_1 = 5'd10;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    push(5'd12, 32'hA2);
    wait_strobe();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expq.delete();
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_enable", {31'd0, write_register_enable}, 32'd0);
    check("mid_rst_pending", {31'd0, pending_1}, 32'd0);
    check("mid_rst_timeout", {31'd0, wb_timeout}, 32'd0);
    repeat (20) step();

    check("scoreboard_empty", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
